load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Bridges the CPU execute stage to data_memory (256 x 16-bit, 1-cycle registered read, ignores all
//  accesses while suspend_cpu=1). Accepts word/byte loads and stores on a 9-bit byte address. Byte
//  stores use read-modify-write; loads get sign/zero extension. Back-pressures the pipeline via req_ready.
// PARAMETERS
//  ADDR_W  9   byte address width; word address = req_addr[ADDR_W-1:1]
//  DATA_W  16  memory word width; 2 byte lanes, little-endian (byte 0 = bits [7:0])
// PORTS
//  clk          in   1   clock
//  rstn         in   1   asynchronous active-low reset
//  suspend_cpu  in   1   global freeze, shared with data_memory
//  req_valid    in   1   CPU request valid
//  req_op       in   3   LW=0, LB=1, LBU=2, SW=3, SB=4; 5-7 illegal
//  req_addr     in   9   byte address
//  req_wdata    in   16  store data (SB uses [7:0])
//  req_ready    out  1   request accepted when req_valid & req_ready & !suspend_cpu
//  rsp_valid    out  1   load data valid, 1-cycle pulse
//  rsp_data     out  16  load result, extended
//  err          out  1   1-cycle pulse: misaligned word access or illegal op
//  mem_address  out  8   to data_memory_address
//  mem_write    out  16  to data_memory_write
//  mem_write_en out  1   to data_memory_write_en
//  mem_read_en  out  1   to data_memory_read_en
//  mem_read     in   16  from data_memory_read
// BEHAVIOUR
//  Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, err=0, mem_*_en=0, mem_address=0,
//   mem_write=0, captured op/addr/wdata regs=0. Reset mid-operation drops the pending op (no write).
//  FSM states: IDLE, LOAD_RSP, SB_MERGE. req_ready=1 only in IDLE and !suspend_cpu.
//  mem_* outputs combinational from FSM; request captured into regs on accept.
//  IDLE, accept:
//   SW aligned  -> mem_write_en=1, mem_address=addr[8:1], mem_write=wdata same cycle; stay IDLE.
//   LW aligned, LB, LBU -> mem_read_en=1 same cycle; -> LOAD_RSP.
//   SB          -> mem_read_en=1 same cycle; -> SB_MERGE.
//   LW/SW with addr[0]=1 or op 5-7 -> no memory enable; err=1 next cycle (registered); stay IDLE.
//  LOAD_RSP: rsp_valid=1; LW: rsp_data=mem_read; LB/LBU: selected byte (addr[0]) sign-/zero-extended
//   to 16 bits. -> IDLE. Load latency: accept at cycle N, rsp_valid at N+1; throughput 1 load / 2 cycles.
//  SB_MERGE: mem_write_en=1, mem_address=captured word addr, mem_write=mem_read with lane addr[0]
//   replaced by wdata[7:0]; other lane unchanged. -> IDLE. Total 2 cycles, req_ready=0 during merge.
//  mem_read_en and mem_write_en never asserted in the same cycle.
//  suspend_cpu=1: FSM, captured regs and err frozen; no accept; mem_*_en, rsp_valid forced 0;
//   pending LOAD_RSP/SB_MERGE completes on the first cycle after suspend deasserts (mem_read held by memory).
//  No store-to-load forwarding needed: all accesses serialised through one FSM.
// STRUCTURE
//  lsu_pkg: lsu_op_e enum (LW..SB), lsu_state_e enum, DATA_W/ADDR_W localparams, lane select helper.
//  Sub-module lsu_byte_lane (combinational): byte extract + sign/zero extend, byte merge into word;
//   instantiated once, shared by LOAD_RSP and SB_MERGE paths.
// TESTING (memory model = data_memory behaviour incl. suspend gating)
//  1 SW addr=0x010 wdata=0xBEEF, then LW 0x010 -> write word 0x08 in 1 cycle; rsp_valid 1 cycle
//    after LW accept, rsp_data=0xBEEF; req_ready low exactly 1 cycle.
//  2 Word 0x20=0x80A5: LB 0x040 -> 0xFFA5; LBU 0x041 -> 0x0080; LB 0x041 -> 0xFF80.
//  3 Word 0x05=0x1234, SB 0x00B wdata=0x00CC -> word 0x05=0xCC34; SB 0x00A wdata=0x0077 -> 0xCC77;
//    read and write enables in consecutive cycles, never together.
//  4 LW 0x003 and op=6 -> err pulses 1 cycle each, no mem enable, no rsp_valid, memory unchanged.
//  5 suspend_cpu=1 for 3 cycles right after SB accept -> no write, req_ready=0 during suspend;
//    merge write lands on first cycle after release with correct data.
//  6 rstn asserted in SB_MERGE cycle -> no write reaches memory; after release req_ready=1, all
//    outputs at reset values; next LW returns pre-SB word.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, widths and lane helper for the load/store unit
// Purpose: operation and FSM state enums plus the default address/data widths.
// Contents: LSU_ADDR_W, LSU_DATA_W, lsu_op_e, lsu_state_e, lane_sel().
package lsu_pkg;

  localparam int LSU_ADDR_W = 9;
  localparam int LSU_DATA_W = 16;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LB  = 3'd1,
    LBU = 3'd2,
    SW  = 3'd3,
    SB  = 3'd4
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_RSP = 2'd1,
    ST_SB_MERGE = 2'd2
  } lsu_state_e;

  // Little-endian: address bit 0 picks the byte lane (0 = bits [7:0]).
  function automatic logic lane_sel(input logic [LSU_ADDR_W-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - byte extract/extend and byte merge for a 16-bit word
// Purpose: shared byte datapath for byte loads and byte-store read-modify-write.
// Ports: word (memory word), lane (byte select), sign_ext (1 = LB), byte_in (store byte),
//        ext_out (selected byte extended to 16 bits), merged (word with lane replaced).
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [LSU_DATA_W-1:0] word,
  input  logic                  lane,
  input  logic                  sign_ext,
  input  logic [7:0]            byte_in,
  output logic [LSU_DATA_W-1:0] ext_out,
  output logic [LSU_DATA_W-1:0] merged
);

  logic [7:0] sel;

  always_comb begin
    sel     = lane ? word[15:8] : word[7:0];
    ext_out = {{8{sign_ext & sel[7]}}, sel};
    merged  = lane ? {byte_in, word[7:0]} : {word[15:8], byte_in};
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - CPU load/store bridge to a 1-cycle registered data memory
// Purpose: word/byte loads with extension, word stores, byte stores via read-modify-write.
// Ports: clk, rstn (async active-low), suspend_cpu (global freeze),
//        req_valid/req_op/req_addr/req_wdata/req_ready (CPU request),
//        rsp_valid/rsp_data (load result), err (misaligned or illegal op pulse),
//        mem_address/mem_write/mem_write_en/mem_read_en/mem_read (data memory).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              suspend_cpu,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              err,
  output logic [ADDR_W-2:0] mem_address,
  output logic [DATA_W-1:0] mem_write,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_read
);

  lsu_state_e        state_q, state_d;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wbyte_q;
  logic              err_q;

  logic              accept;
  logic              req_illegal;
  logic [DATA_W-1:0] lane_ext;
  logic [DATA_W-1:0] lane_merged;

  // Word ops need an even address; encodings above SB are undefined.
  always_comb begin
    req_illegal = (req_op > 3'(SB)) ||
                  (((req_op == 3'(LW)) || (req_op == 3'(SW))) && lane_sel(req_addr));
  end

  // Byte lane always looks at the captured request: both consumers (LOAD_RSP and
  // SB_MERGE) act on the memory word returned one cycle after the accept.
  lsu_byte_lane u_byte_lane (
    .word     (mem_read),
    .lane     (lane_sel(addr_q)),
    .sign_ext (op_q == 3'(LB)),
    .byte_in  (wbyte_q),
    .ext_out  (lane_ext),
    .merged   (lane_merged)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wbyte_q <= '0;
      err_q   <= 1'b0;
    end else if (!suspend_cpu) begin
      state_q <= state_d;
      err_q   <= accept & req_illegal;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wbyte_q <= req_wdata[7:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_data     = '0;
    mem_address  = '0;
    mem_write    = '0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = !suspend_cpu;
        accept    = req_valid & !suspend_cpu;
        if (accept && !req_illegal) begin
          mem_address = req_addr[ADDR_W-1:1];
          if (req_op == 3'(SW)) begin
            mem_write_en = 1'b1;
            mem_write    = req_wdata;
          end else begin
            mem_read_en = 1'b1;
            state_d     = (req_op == 3'(SB)) ? ST_SB_MERGE : ST_LOAD_RSP;
          end
        end
      end

      ST_LOAD_RSP: begin
        mem_address = addr_q[ADDR_W-1:1];
        // Memory holds mem_read across suspend, so completion simply waits.
        if (!suspend_cpu) begin
          rsp_valid = 1'b1;
          rsp_data  = (op_q == 3'(LW)) ? mem_read : lane_ext;
          state_d   = ST_IDLE;
        end
      end

      ST_SB_MERGE: begin
        mem_address = addr_q[ADDR_W-1:1];
        if (!suspend_cpu) begin
          mem_write_en = 1'b1;
          mem_write    = lane_merged;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign err = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a data_memory model
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        suspend_cpu = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = '0;
  logic [8:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, rsp_valid, err;
  logic [15:0] rsp_data;
  logic [7:0]  mem_address;
  logic [15:0] mem_write;
  logic        mem_write_en, mem_read_en;
  logic [15:0] mem_read;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk          (clk),
    .rstn         (rstn),
    .suspend_cpu  (suspend_cpu),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .err          (err),
    .mem_address  (mem_address),
    .mem_write    (mem_write),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en),
    .mem_read     (mem_read)
  );

  // data_memory model: 1-cycle registered read, all accesses ignored under suspend.
  logic [15:0] mem [256];
  logic        pl_en = 1'b0, clr = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  int          rd_cnt = 0, wr_cnt = 0, overlap_cnt = 0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem_read <= '0;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (!suspend_cpu) begin
      if (mem_write_en) mem[mem_address] <= mem_write;
      if (mem_read_en)  mem_read <= mem[mem_address];
    end
    if (rstn && !suspend_cpu) begin
      if (mem_read_en)  rd_cnt <= rd_cnt + 1;
      if (mem_write_en) wr_cnt <= wr_cnt + 1;
      if (mem_read_en && mem_write_en) overlap_cnt <= overlap_cnt + 1;
    end
  end

  // Reference model: byte-addressed memory image.
  logic [7:0] ref_b [512];

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_word(input int w);
    return {ref_b[2*w+1], ref_b[2*w]};
  endfunction

  task automatic preload(input int w, input logic [15:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = 8'(w); pl_data = v;
    ref_b[2*w] = v[7:0]; ref_b[2*w+1] = v[15:8];
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One complete request; checks handshake, timing, enables and memory against the model.
  task automatic xact(input logic [2:0] op, input logic [8:0] addr, input logic [15:0] wd,
                      input string nm, output logic [15:0] got_rsp, output int got_err);
    int a, w, rd0, wr0, rsp_cnt, rsp_first, v, exp_rd, exp_wr;
    bit legal, is_load, is_sb, is_sw;
    logic [15:0] exp;
    a = int'(addr); w = a / 2;
    legal   = (op <= 3'd4) && !(((op == 3'd0) || (op == 3'd3)) && (a % 2 == 1));
    is_load = legal && (op <= 3'd2);
    is_sb   = legal && (op == 3'd4);
    is_sw   = legal && (op == 3'd3);
    exp = '0;
    if (is_load) begin
      if (op == 3'd0) exp = ref_word(w);
      else if (op == 3'd2) exp = 16'(int'(ref_b[a]));
      else begin
        v = int'(ref_b[a]);
        if (v >= 128) v = v - 256;
        exp = 16'(v);
      end
    end
    exp_rd = (is_load || is_sb) ? 1 : 0;
    exp_wr = (is_sw || is_sb) ? 1 : 0;

    @(negedge clk);
    rd0 = rd_cnt; wr0 = wr_cnt;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    #1 check({nm, "_ready_accept"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    got_rsp = '0; got_err = 0; rsp_cnt = 0; rsp_first = -1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (c == 0) check({nm, "_ready_busy"}, 32'(req_ready), 32'(!(is_load || is_sb)));
      if (c == 1) check({nm, "_ready_back"}, 32'(req_ready), 32'd1);
      if (rsp_valid) begin
        if (rsp_cnt == 0) begin rsp_first = c; got_rsp = rsp_data; end
        rsp_cnt++;
      end
      if (err) got_err++;
      @(negedge clk);
    end
    check({nm, "_rsp_count"}, 32'(rsp_cnt), 32'(is_load));
    if (is_load) begin
      check({nm, "_rsp_cycle"}, 32'(rsp_first), 32'd0);
      check({nm, "_rsp_data"}, 32'(got_rsp), 32'(exp));
    end
    check({nm, "_err_count"}, 32'(got_err), 32'(!legal));
    check({nm, "_rd_en"}, 32'(rd_cnt - rd0), 32'(exp_rd));
    check({nm, "_wr_en"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    if (is_sw) begin ref_b[a] = wd[7:0]; ref_b[a+1] = wd[15:8]; end
    if (is_sb) ref_b[a] = wd[7:0];
    check({nm, "_mem"}, 32'(mem[w]), 32'(ref_word(w)));
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [8:0]  addr;
    logic [15:0] wd;
    logic [15:0] exp_rsp;
    logic        exp_err;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [15:0] r;
    int e;
    tbl[0]  = '{3'd3, 9'h010, 16'hBEEF, 16'h0000, 1'b0};
    tbl[1]  = '{3'd0, 9'h010, 16'h0000, 16'hBEEF, 1'b0};
    tbl[2]  = '{3'd1, 9'h040, 16'h0000, 16'hFFA5, 1'b0};
    tbl[3]  = '{3'd2, 9'h041, 16'h0000, 16'h0080, 1'b0};
    tbl[4]  = '{3'd1, 9'h041, 16'h0000, 16'hFF80, 1'b0};
    tbl[5]  = '{3'd4, 9'h00B, 16'h00CC, 16'h0000, 1'b0};
    tbl[6]  = '{3'd0, 9'h00A, 16'h0000, 16'hCC34, 1'b0};
    tbl[7]  = '{3'd4, 9'h00A, 16'h0077, 16'h0000, 1'b0};
    tbl[8]  = '{3'd0, 9'h00A, 16'h0000, 16'hCC77, 1'b0};
    tbl[9]  = '{3'd0, 9'h003, 16'h0000, 16'h0000, 1'b1};
    tbl[10] = '{3'd6, 9'h020, 16'h1111, 16'h0000, 1'b1};

    for (int i = 0; i < 512; i++) ref_b[i] = 8'h00;

    // Reset values
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_en", 32'({mem_read_en, mem_write_en}), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_wdata", 32'(mem_write), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Directed table
    preload(8'h20, 16'h80A5);
    preload(8'h05, 16'h1234);
    for (int i = 0; i < 11; i++) begin
      xact(tbl[i].op, tbl[i].addr, tbl[i].wd, $sformatf("tbl%0d", i), r, e);
      if (tbl[i].op <= 3'd2 && !tbl[i].exp_err)
        check($sformatf("tbl%0d_const_rsp", i), 32'(r), 32'(tbl[i].exp_rsp));
      check($sformatf("tbl%0d_const_err", i), 32'(e), 32'(tbl[i].exp_err));
    end

    // Suspend right after SB accept: merge waits, then writes correct data
    preload(8'h30, 16'hA1B2);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; req_addr = 9'h061; req_wdata = 16'h005C;
    @(negedge clk);
    req_valid = 1'b0; suspend_cpu = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("susp%0d_we", c), 32'(mem_write_en), 32'd0);
      check($sformatf("susp%0d_ready", c), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    check("susp_mem_held", 32'(mem[8'h30]), 32'hA1B2);
    suspend_cpu = 1'b0;
    #1;
    check("susp_rel_we", 32'(mem_write_en), 32'd1);
    check("susp_rel_addr", 32'(mem_address), 32'h30);
    check("susp_rel_data", 32'(mem_write), 32'h5CB2);
    @(negedge clk);
    ref_b[9'h061] = 8'h5C;
    #1;
    check("susp_mem_after", 32'(mem[8'h30]), 32'h5CB2);
    check("susp_ready_after", 32'(req_ready), 32'd1);

    // Reset during SB_MERGE drops the write
    preload(8'h40, 16'h1357);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; req_addr = 9'h080; req_wdata = 16'h00AA;
    @(negedge clk);
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    rstn = 1'b0;
    #1;
    check("rstmid_ready", 32'(req_ready), 32'd1);
    check("rstmid_en", 32'({mem_read_en, mem_write_en}), 32'd0);
    check("rstmid_outs", 32'({rsp_valid, err}), 32'd0);
    check("rstmid_addr", 32'(mem_address), 32'd0);
    check("rstmid_wdata", 32'(mem_write), 32'd0);
    check("rstmid_rdata", 32'(rsp_data), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    check("rstmid_mem", 32'(mem[8'h40]), 32'h1357);
    xact(3'd0, 9'h080, 16'h0, "rstmid_lw", r, e);
    check("rstmid_lw_val", 32'(r), 32'h1357);

    // Randomised traffic against the byte-image model
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  op;
      logic [8:0]  ad;
      logic [15:0] wd;
      op = 3'($urandom_range(0, 7));
      ad = 9'($urandom_range(0, 511));
      if (op == 3'd0 || op == 3'd3) if ($urandom_range(0, 3) != 0) ad[0] = 1'b0;
      wd = 16'($urandom);
      xact(op, ad, wd, $sformatf("rnd%0d", i), r, e);
    end

    check("no_rd_wr_overlap", 32'(overlap_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
